// File: rtl/seq_mul_responder_if.sv
// Request/acknowledge bus between the ALU control path (master) and the
// sequential multiplier (slave).
interface seq_mul_responder_if #(
  parameter int WIDTH = 16
);
  logic                 iRequest;
  logic [WIDTH-1:0]     iOperandA;
  logic [WIDTH-1:0]     iOperandB;
  logic                 oBusy;
  logic                 oDone;
  logic [2*WIDTH-1:0]   oResult;
  logic                 oOverflow;

  modport master (
    output iRequest, iOperandA, iOperandB,
    input  oBusy, oDone, oResult, oOverflow
  );

  modport slave (
    input  iRequest, iOperandA, iOperandB,
    output oBusy, oDone, oResult, oOverflow
  );
endinterface

// File: rtl/seq_mul_responder.sv
// Shift-add unsigned multiplier, WIDTH iterations per product, answering a
// four-phase request with a level acknowledge held until the request drops.
module seq_mul_responder #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  seq_mul_responder_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q,    state_d;
  logic [2*WIDTH-1:0]   a_q,        a_d;
  logic [WIDTH-1:0]     b_q,        b_d;
  logic [2*WIDTH-1:0]   acc_q,      acc_d;
  logic [CW-1:0]        cnt_q,      cnt_d;
  logic [2*WIDTH-1:0]   result_q,   result_d;
  logic                 overflow_q, overflow_d;
  logic [2*WIDTH-1:0]   acc_sum;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    acc_sum    = b_q[0] ? (acc_q + a_q) : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.iRequest) begin
          a_d     = {{WIDTH{1'b0}}, bus.iOperandA};
          b_d     = bus.iOperandB;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // The final iteration publishes the sum it has just formed.
        if (cnt_q == LAST_ITER) begin
          result_d   = acc_sum;
          overflow_d = |acc_sum[2*WIDTH-1:WIDTH];
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.iRequest) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.oBusy     = (state_q == S_RUN);
  assign bus.oDone     = (state_q == S_DONE);
  assign bus.oResult   = result_q;
  assign bus.oOverflow = overflow_q;

endmodule

// File: tb/tb_seq_mul_responder.sv
// Randomised scoreboard bench for seq_mul_responder: the driver queues the
// arithmetic product of each accepted request; a monitor checks completions.
module tb_seq_mul_responder;

  localparam int WIDTH = 16;
  localparam int LATENCY = 16;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  seq_mul_responder_if #(.WIDTH(WIDTH)) bus ();

  seq_mul_responder #(.WIDTH(WIDTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] prod;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: plain integer multiplication; overflow when it exceeds 16 bits.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    int unsigned p;
    exp_t r;
    p      = int'(a) * int'(b);
    r.prod = p;
    r.ovf  = (p > 32'h0000_FFFF);
    return r;
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(posedge Clock);
    #1;
    bus.iOperandA = a;
    bus.iOperandB = b;
    bus.iRequest  = 1'b1;
    exp_q.push_back(model(a, b));
  endtask

  task automatic wait_done();
    int cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
    end while (!bus.oDone && cyc < 40);
    check("done_timeout", 64'(bus.oDone), 64'(1));
  endtask

  task automatic release_req();
    @(posedge Clock);
    #1 bus.iRequest = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check("done_clear", 64'(bus.oDone), 64'(0));
    check("idle_not_busy", 64'(bus.oBusy), 64'(0));
  endtask

  // Monitor: pops one expectation per rising acknowledge.
  initial begin
    logic        prev_done = 1'b0;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_res  = '0;
    logic        prev_ovf  = 1'b0;
    int          busy_cnt  = 0;
    exp_t        e;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        prev_done = 1'b0;
        prev_busy = 1'b0;
        prev_res  = '0;
        prev_ovf  = 1'b0;
        busy_cnt  = 0;
        exp_q.delete();
      end else begin
        if (bus.oBusy && !prev_busy) begin
          busy_cnt = 1;
          check("start_has_pending", 64'(exp_q.size() != 0), 64'(1));
        end else if (bus.oBusy) begin
          busy_cnt++;
        end
        if (bus.oDone && !prev_done) begin
          check("busy_done_exclusive", 64'(bus.oBusy), 64'(0));
          check("latency", 64'(busy_cnt), 64'(LATENCY));
          check("done_has_pending", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result", 64'(bus.oResult), 64'(e.prod));
            check("overflow", 64'(bus.oOverflow), 64'(e.ovf));
          end
        end else if ({bus.oResult, bus.oOverflow} != {prev_res, prev_ovf}) begin
          check("result_hold", 64'({bus.oResult, bus.oOverflow}), 64'({prev_res, prev_ovf}));
        end
        prev_done = bus.oDone;
        prev_busy = bus.oBusy;
        prev_res  = bus.oResult;
        prev_ovf  = bus.oOverflow;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb;
    Reset         = 1'b1;
    bus.iRequest  = 1'b0;
    bus.iOperandA = '0;
    bus.iOperandB = '0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("reset_busy", 64'(bus.oBusy), 64'(0));
    check("reset_done", 64'(bus.oDone), 64'(0));
    check("reset_result", 64'(bus.oResult), 64'(0));
    check("reset_overflow", 64'(bus.oOverflow), 64'(0));

    // 3 x 5 with request held through the acknowledge.
    start_op(16'd3, 16'd5);
    wait_done();
    repeat (3) begin
      @(negedge Clock);
      check("done_stays", 64'(bus.oDone), 64'(1));
    end
    release_req();

    // Largest operands, then a zero multiplier.
    start_op(16'hFFFF, 16'hFFFF);
    wait_done();
    release_req();
    start_op(16'h1234, 16'h0000);
    wait_done();
    release_req();

    // Operand changes and a request glitch during RUN are ignored.
    start_op(16'h00FF, 16'h0101);
    repeat (4) @(posedge Clock);
    #1;
    bus.iRequest  = 1'b0;
    bus.iOperandA = 16'hAAAA;
    bus.iOperandB = 16'h5555;
    repeat (2) @(posedge Clock);
    #1 bus.iRequest = 1'b1;
    wait_done();
    release_req();

    // Long hold gives no recomputation; a one-cycle drop then re-arms.
    start_op(16'h0042, 16'h0101);
    wait_done();
    repeat (10) begin
      @(negedge Clock);
      check("hold_done", 64'(bus.oDone), 64'(1));
      check("hold_not_busy", 64'(bus.oBusy), 64'(0));
    end
    @(posedge Clock);
    #1 bus.iRequest = 1'b0;
    @(posedge Clock);
    #1;
    bus.iRequest  = 1'b1;
    bus.iOperandA = 16'h7777;
    bus.iOperandB = 16'h0003;
    exp_q.push_back(model(16'h7777, 16'h0003));
    @(negedge Clock);
    check("rearm_idle_done", 64'(bus.oDone), 64'(0));
    check("rearm_idle_busy", 64'(bus.oBusy), 64'(0));
    @(negedge Clock);
    check("rearm_accepted", 64'(bus.oBusy), 64'(1));
    wait_done();
    release_req();

    // Reset on the 7th RUN edge aborts the operation.
    start_op(16'h0100, 16'h0100);
    repeat (7) @(posedge Clock);
    #1;
    Reset        = 1'b1;
    bus.iRequest = 1'b0;
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("abort_busy", 64'(bus.oBusy), 64'(0));
    check("abort_done", 64'(bus.oDone), 64'(0));
    check("abort_result", 64'(bus.oResult), 64'(0));
    check("abort_overflow", 64'(bus.oOverflow), 64'(0));
    start_op(16'h0100, 16'h0100);
    wait_done();
    release_req();

    // Back-to-back random operand pairs, with a few forced corners mixed in.
    for (int i = 0; i < 220; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 37 == 0) ra = 16'hFFFF;
      if (i % 41 == 0) rb = 16'h0001;
      if (i % 53 == 0) ra = 16'h0000;
      start_op(ra, rb);
      wait_done();
      release_req();
    end

    repeat (5) @(negedge Clock);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mul_responder.md
Name: seq_mul_responder

Overview:
Multi-cycle shift-add unsigned multiplier that acts as the responder side of a MUL request/acknowledge interface. The ALU control path raises a request carrying two register-file operands. The block computes the full-width product over WIDTH cycles and acknowledges with a four-phase handshake. It replaces the combinational multiplier array with a small sequential unit whose timing is deterministic.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits.

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
iRequest  input  1  four-phase request level from initiator
iOperandA  input  WIDTH  multiplicand; sampled only on acceptance
iOperandB  input  WIDTH  multiplier; sampled only on acceptance
oBusy  output  1  high while iterations are in progress (state RUN)
oDone  output  1  acknowledge level (state DONE)
oResult  output  2*WIDTH  registered product; holds until next completion
oOverflow  output  1  registered; 1 when oResult[2*WIDTH-1:WIDTH] != 0, i.e. the product does not fit in the 16-bit ALU result

Behaviour:
- Reset, sampled at a rising edge, has priority over all other inputs, including mid-operation. On reset: state IDLE, oBusy=0, oDone=0, oResult=0, oOverflow=0, iteration counter=0, internal operand and accumulator registers=0.
- State IDLE: oBusy=0, oDone=0.
  - iRequest=1 at edge E0 -> latch A into a 2*WIDTH shift register (zero-extended), latch B into a WIDTH shift register, clear the accumulator and counter, go to RUN.
  - iRequest=0 -> stay in IDLE.
- State RUN: oBusy=1.
  - At each edge, if B_reg[0]=1 then acc <= acc + A_reg (2*WIDTH-bit add, no truncation possible). Then A_reg <<= 1, B_reg >>= 1, counter++.
  - Exactly WIDTH iterations, at edges E1..E_WIDTH. There is no early termination; latency does not depend on the data.
  - At edge E_WIDTH: oResult <= final acc (including that edge's addition), oOverflow <= high-half OR, state -> DONE.
- State DONE: oBusy=0, oDone=1.
  - Stays in DONE while iRequest=1.
  - First edge with iRequest=0 -> IDLE, oDone=0.
  - A new request is accepted no earlier than the edge after returning to IDLE. The initiator must drop and re-raise iRequest; a held request never triggers a repeat multiply.
- Latency: the first cycle with oDone=1 begins WIDTH edges after the accepting edge. For WIDTH=16: accept at E0, oDone high after E16.
- iOperandA and iOperandB changes while in RUN or DONE are ignored. iRequest is ignored in RUN.
- oResult and oOverflow change only at the completion edge or on reset. They keep the previous product through IDLE and through the RUN of the next operation.
- oBusy and oDone are never high together. Both derive from registered state (no combinational path from inputs).
- Counter width is $clog2(WIDTH)+1. There is no wrap-around, because RUN exits at count WIDTH.

Test Plan:
1. Reset, then A=3, B=5, iRequest held -> oBusy high for 16 cycles; oDone rises 16 edges after acceptance; oResult=0x0000000F, oOverflow=0; oDone stays 1 until iRequest drops, then clears on the next edge.
2. A=0xFFFF, B=0xFFFF -> oResult=0xFFFE0001, oOverflow=1. Then A=0x1234, B=0 -> oResult=0, oOverflow=0, latency still 16.
3. Accept A=0x00FF, B=0x0101. Change operands to 0xAAAA/0x5555 during RUN and pulse iRequest low/high during RUN -> oResult=0x0000FFFF, oOverflow=0; no second operation starts.
4. Hold iRequest high for 10 cycles after oDone rises -> oDone stays 1 and no recomputation. Drop it for 1 cycle and re-raise -> new acceptance occurs only after the IDLE edge.
5. Assert Reset at the 7th RUN edge of A=0x0100, B=0x0100 -> next cycle all outputs 0, state IDLE. A new request with the same operands -> oResult=0x00010000, oOverflow=1, full 16-cycle latency.
6. Back-to-back randomised unsigned operand pairs (≥200), compared against a reference product -> oResult matches exactly, oOverflow matches the high-half test, each transaction takes exactly 16 RUN cycles.
